// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: M-op func3 codes,
// FSM state encodings and operand-signedness decode.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011,
        M_DIV    = 3'b100,
        M_DIVU   = 3'b101,
        M_REM    = 3'b110,
        M_REMU   = 3'b111
    } mop_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_SIGN = 2'b10,
        MDU_DONE = 2'b11
    } mdu_state_e;

    function automatic logic rs1_signed(input logic [2:0] f3);
        return f3 inside {M_MUL, M_MULH, M_MULHSU, M_DIV, M_REM};
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f3);
        return f3 inside {M_MUL, M_MULH, M_DIV, M_REM};
    endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// Iteration engine: 2*XLEN accumulator plus step counter. Each step is one
// shift-add (multiply) or one restoring shift-subtract (divide) on magnitudes.
module mdu_shift_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   load_val,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc,
    output logic              last
);

    localparam logic [XLEN-1:0] LAST_CNT = XLEN'(XLEN - 1);

    logic [XLEN-1:0]   cnt;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     sub_diff;
    logic [2*XLEN-1:0] acc_nxt;

    // Divide: the top XLEN+1 bits are the shifted partial remainder with the
    // next dividend bit; a clear borrow bit means the subtraction is kept.
    always_comb begin
        add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        sub_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
        if (!is_div)
            acc_nxt = {add_sum, acc[XLEN-1:1]};
        else if (!sub_diff[XLEN])
            acc_nxt = {sub_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_nxt = {acc[2*XLEN-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= {{XLEN{1'b0}}, load_val};
            cnt <= '0;
        end else if (step) begin
            acc <= acc_nxt;
            cnt <= cnt + XLEN'(1);
        end
    end

    assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, sign pre/post processing,
// divide fast paths and the valid/ready result handshake.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_func3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam logic [XLEN-1:0] MIN_SIGNED = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state, state_nxt;
    logic [2:0]        op;
    logic              neg;
    logic [XLEN-1:0]   mag_b;
    logic              accept, sign_a, sign_b, div_zero, div_ovf, fast, last;
    logic [XLEN-1:0]   mag_a_in, mag_b_in, fast_res, sign_res, part;
    logic [2*XLEN-1:0] acc, prod;

    assign accept   = in_valid && in_ready && !flush;
    assign sign_a   = rs1_signed(in_func3) && in_rs1[XLEN-1];
    assign sign_b   = rs2_signed(in_func3) && in_rs2[XLEN-1];
    assign mag_a_in = sign_a ? -in_rs1 : in_rs1;
    assign mag_b_in = sign_b ? -in_rs2 : in_rs2;

    // func3[1] separates REM* from DIV* within the divide group.
    assign div_zero = in_func3[2] && (in_rs2 == '0);
    assign div_ovf  = ((in_func3 == M_DIV) || (in_func3 == M_REM)) &&
                      (in_rs1 == MIN_SIGNED) && (in_rs2 == '1);
    assign fast     = div_zero || div_ovf;
    assign fast_res = div_zero ? (in_func3[1] ? in_rs1 : '1)
                               : (in_func3[1] ? '0 : MIN_SIGNED);

    always_ff @(posedge clk) begin
        if (!rstn) state <= MDU_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MDU_IDLE: if (accept)    state_nxt = fast ? MDU_DONE : MDU_CALC;
            MDU_CALC: if (last)      state_nxt = MDU_SIGN;
            MDU_SIGN:                state_nxt = MDU_DONE;
            MDU_DONE: if (out_ready) state_nxt = MDU_IDLE;
            default:                 state_nxt = MDU_IDLE;
        endcase
        if (flush) state_nxt = MDU_IDLE;
    end

    always_comb begin
        in_ready  = (state == MDU_IDLE);
        busy      = (state != MDU_IDLE);
        out_valid = (state == MDU_DONE);
    end

    mdu_shift_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .rstn     (rstn),
        .load     (accept && !fast),
        .step     (state == MDU_CALC),
        .is_div   (op[2]),
        .load_val (mag_a_in),
        .operand  (mag_b),
        .acc      (acc),
        .last     (last)
    );

    always_comb begin
        prod = neg ? -acc : acc;
        part = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        if (!op[2])
            sign_res = (op == M_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else
            sign_res = neg ? -part : part;
    end

    // Remainder takes the dividend's sign; product and quotient take sA^sB.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            op         <= '0;
            neg        <= 1'b0;
            mag_b      <= '0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (accept) begin
            op      <= in_func3;
            mag_b   <= mag_b_in;
            out_tag <= in_tag;
            neg     <= (in_func3[2] && in_func3[1]) ? sign_a : (sign_a ^ sign_b);
            if (fast) out_result <= fast_res;
        end else if (state == MDU_SIGN) begin
            out_result <= sign_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit with directed RV32M vectors,
// backpressure, flush and mid-operation reset scenarios.
module tb_muldiv_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam logic [31:0] MINS = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  in_func3 = '0;
    logic [31:0] in_rs1 = '0, in_rs2 = '0;
    logic [4:0]  in_tag = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;
    exp_t sb_q[$];

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_func3   (in_func3),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic over the RV32M definitions.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINS && b == 32'hFFFF_FFFF) return MINS;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = 64'(ua / ub); return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MINS && b == 32'hFFFF_FFFF) return 32'h0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = 64'(ua % ub); return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return (f[2] && b == 0) || ((f == 3'd4 || f == 3'd6) && a == MINS && b == 32'hFFFF_FFFF);
    endfunction

    // Latency is counted in edges including the accept edge (fast path = 1).
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input logic [31:0] e, input int hold);
        int lat;
        int n;
        lat = is_fast(f, a, b) ? 1 : XLEN + 2;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: in_ready stayed %b, expected 1", in_ready);
            return;
        end
        out_ready = (hold == 0);
        in_valid = 1'b1; in_func3 = f; in_rs1 = a; in_rs2 = b; in_tag = t;
        @(posedge clk);
        sb_q.push_back(exp_t'{res: e, tag: t});
        #1 in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        chk("latency", 32'(n), 32'(lat));
        for (int i = 0; i < hold; i++) begin
            chk("hold_result", out_result, e);
            chk("hold_tag", 32'(out_tag), 32'(t));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        if (hold > 0) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk("idle_after_ready", 32'(in_ready), 32'd1);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        @(negedge clk);
        in_valid = 1'b1; in_func3 = 3'd0; in_rs1 = a; in_rs2 = b; in_tag = t;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rstn && !flush && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: got %h tag %0d, expected no result", out_result, out_tag);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", out_result, e.res);
                chk("tag", 32'(out_tag), 32'(e.tag));
            end
        end
    end

    logic [2:0]  d_f [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] d_a [12] = '{32'd7, MINS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'd5, 32'd5, MINS, MINS};
    logic [31:0] d_b [12] = '{32'hFFFF_FFFD, MINS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_e [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, MINS, 32'd0};

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return MINS;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        @(negedge clk) rstn = 1'b1;

        for (int i = 0; i < 12; i++)
            issue(d_f[i], d_a[i], d_b[i], 5'(i + 1), d_e[i], 0);

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd21, 32'hFFFF_FFEB, 5);
        issue(3'd5, 32'd5, 32'd0, 5'd22, 32'hFFFF_FFFF, 3);

        // Accept presented together with flush must be dropped.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_func3 = 3'd0; in_rs1 = 32'd9; in_rs2 = 32'd9; in_tag = 5'd3;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_ready", 32'(in_ready), 32'd1);
        chk("flush_accept_busy", 32'(busy), 32'd0);

        start_op(32'd1234, 32'd5678, 5'd9);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);
        repeat (40) @(posedge clk);
        #1 chk("flush_no_late_valid", 32'(out_valid), 32'd0);
        issue(3'd0, 32'd3, 32'd4, 5'd12, 32'd12, 0);

        start_op(32'd77, 32'd88, 5'd17);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_result", out_result, 32'd0);
        chk("mid_rst_tag", 32'(out_tag), 32'd0);
        @(negedge clk) rstn = 1'b1;
        issue(3'd0, 32'd3, 32'd4, 5'd13, 32'd12, 0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            issue(f, a, b, 5'($urandom), ref_model(f, a, b), int'($urandom_range(0, 2)));
        end

        repeat (4) @(posedge clk);
        #1 chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
